// File: rtl/conv_loader.sv
// rtl/conv_loader.sv - memory-to-stream loader feeding activations, weights and a trigger to the conv core
module conv_loader #(
    parameter int MIN_GAP = 0,
    parameter int AW      = 26,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] act_base,
    input  logic [AW-1:0] wgt_base,
    input  logic [4:0]    Hp,
    input  logic [4:0]    Wp,
    input  logic [7:0]    I,
    input  logic [7:0]    O,
    input  logic [2:0]    K,
    output logic          rvalid,
    output logic [AW-1:0] raddr,
    input  logic          rready,
    input  logic [DW-1:0] rdata,
    output logic          din_valid,
    output logic [15:0]   din_data,
    output logic          busy,
    output logic          done
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CALC    = 3'd1;
    localparam logic [2:0] ST_ACT_REQ = 3'd2;
    localparam logic [2:0] ST_WGT_REQ = 3'd3;
    localparam logic [2:0] ST_GAP     = 3'd4;
    localparam logic [2:0] ST_TRIG    = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;

    localparam logic [3:0] GAP_LAST = 4'(MIN_GAP);

    logic [2:0]    state;
    logic [AW-1:0] act_base_r;
    logic [AW-1:0] wgt_base_r;
    logic [4:0]    hp_r;
    logic [4:0]    wp_r;
    logic [7:0]    i_r;
    logic [7:0]    o_r;
    logic [2:0]    k_r;
    logic [23:0]   n_act;
    logic [23:0]   n_wgt;
    logic [23:0]   idx;
    logic [3:0]    gap_cnt;
    logic          wgt_phase;
    logic [23:0]   act_prod;
    logic [23:0]   wgt_prod;

    // Upper data bits are never forwarded to the core.
    logic unused_rdata_hi;
    assign unused_rdata_hi = ^rdata[DW-1:16];

    // Tensor sizes from the latched configuration; worst case fits in 24 bits.
    always_comb begin
        act_prod = 24'(i_r) * 24'(hp_r) * 24'(wp_r);
        wgt_prod = 24'(o_r) * 24'(i_r) * 24'(k_r) * 24'(k_r);
    end

    // Load sequencer: request/response per word, inter-pulse gap, trailing trigger.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            act_base_r <= '0;
            wgt_base_r <= '0;
            hp_r       <= '0;
            wp_r       <= '0;
            i_r        <= '0;
            o_r        <= '0;
            k_r        <= '0;
            n_act      <= '0;
            n_wgt      <= '0;
            idx        <= '0;
            gap_cnt    <= '0;
            wgt_phase  <= 1'b0;
            rvalid     <= 1'b0;
            raddr      <= '0;
            din_valid  <= 1'b0;
            din_data   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            din_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        act_base_r <= act_base;
                        wgt_base_r <= wgt_base;
                        hp_r       <= Hp;
                        wp_r       <= Wp;
                        i_r        <= I;
                        o_r        <= O;
                        k_r        <= K;
                        busy       <= 1'b1;
                        state      <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    n_act   <= act_prod;
                    n_wgt   <= wgt_prod;
                    idx     <= '0;
                    gap_cnt <= '0;
                    if (act_prod != 24'd0) begin
                        wgt_phase <= 1'b0;
                        rvalid    <= 1'b1;
                        raddr     <= act_base_r;
                        state     <= ST_ACT_REQ;
                    end else if (wgt_prod != 24'd0) begin
                        wgt_phase <= 1'b1;
                        rvalid    <= 1'b1;
                        raddr     <= wgt_base_r;
                        state     <= ST_WGT_REQ;
                    end else begin
                        din_valid <= 1'b1;
                        din_data  <= 16'h0000;
                        state     <= ST_TRIG;
                    end
                end
                ST_ACT_REQ, ST_WGT_REQ: begin
                    // raddr is held untouched until the memory accepts.
                    if (rready) begin
                        rvalid    <= 1'b0;
                        din_valid <= 1'b1;
                        din_data  <= rdata[15:0];
                        idx       <= idx + 24'd1;
                        gap_cnt   <= '0;
                        state     <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    // The first GAP cycle carries the data pulse; MIN_GAP idle cycles follow.
                    if (gap_cnt != GAP_LAST) begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end else if (!wgt_phase && idx < n_act) begin
                        rvalid <= 1'b1;
                        raddr  <= act_base_r + AW'(idx);
                        state  <= ST_ACT_REQ;
                    end else if (wgt_phase && idx < n_wgt) begin
                        rvalid <= 1'b1;
                        raddr  <= wgt_base_r + AW'(idx);
                        state  <= ST_WGT_REQ;
                    end else if (!wgt_phase && n_wgt != 24'd0) begin
                        wgt_phase <= 1'b1;
                        idx       <= '0;
                        rvalid    <= 1'b1;
                        raddr     <= wgt_base_r;
                        state     <= ST_WGT_REQ;
                    end else begin
                        din_valid <= 1'b1;
                        din_data  <= 16'h0000;
                        gap_cnt   <= '0;
                        state     <= ST_TRIG;
                    end
                end
                ST_TRIG: begin
                    // Trigger pulse is on the first TRIG cycle; then MIN_GAP idle cycles.
                    if (gap_cnt != GAP_LAST) begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end else begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_loader.sv
// tb/tb_conv_loader.sv - randomized scoreboard bench for conv_loader
module tb_conv_loader;

    localparam int G  = 4;
    localparam int AW = 26;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] act_base;
    logic [AW-1:0] wgt_base;
    logic [4:0]    Hp;
    logic [4:0]    Wp;
    logic [7:0]    I;
    logic [7:0]    O;
    logic [2:0]    K;
    logic          rvalid;
    logic [AW-1:0] raddr;
    logic          rready;
    logic [DW-1:0] rdata;
    logic          din_valid;
    logic [15:0]   din_data;
    logic          busy;
    logic          done;

    conv_loader #(.MIN_GAP(G), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .act_base(act_base), .wgt_base(wgt_base),
        .Hp(Hp), .Wp(Wp), .I(I), .O(O), .K(K),
        .rvalid(rvalid), .raddr(raddr), .rready(rready), .rdata(rdata),
        .din_valid(din_valid), .din_data(din_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int start_cyc;
    int budget;

    logic [15:0]   exp_data[$];
    logic [AW-1:0] exp_addr[$];
    bit            stall_en;
    logic [15:0]   salt;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [AW-1:0] a);
        return a[15:0] ^ salt;
    endfunction

    // Memory model: random accept latency, stall stability, spurious rready while idle.
    int            wait_left;
    bit            pending = 0;
    logic [AW-1:0] hold_addr;
    always @(negedge clk) begin
        rready = 1'b0;
        rdata  = $urandom;
        if (rst) begin
            pending = 0;
        end else if (rvalid) begin
            if (!pending) begin
                pending   = 1;
                wait_left = stall_en ? int'($urandom_range(0, 7)) : 0;
                hold_addr = raddr;
            end else begin
                check("stall_raddr_stable", 32'(raddr), 32'(hold_addr));
            end
            if (wait_left == 0) begin
                rready  = 1'b1;
                rdata   = {16'hDEAD, mem_word(raddr)};
                pending = 0;
                if (exp_addr.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL raddr_extra: got %0h expected no request", raddr);
                end else begin
                    check("raddr", 32'(raddr), 32'(exp_addr.pop_front()));
                end
            end else begin
                wait_left--;
            end
        end else begin
            if (pending) begin
                check("rvalid_held_in_stall", 32'(rvalid), 32'd1);
                pending = 0;
            end
            if (stall_en && $urandom_range(0, 3) == 0) rready = 1'b1;
        end
    end

    // Output monitor: pops the scoreboard on every pulse, checks spacing, hold and done.
    int          last_pulse;
    bit          have_last = 0;
    logic [15:0] last_data = '0;
    always @(negedge clk) begin
        if (rst) begin
            have_last = 0;
            last_data = '0;
        end else begin
            if (din_valid) begin
                if (exp_data.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL din_extra: got pulse %0h expected none", din_data);
                end else begin
                    check("din_data", 32'(din_data), 32'(exp_data.pop_front()));
                end
                if (have_last) check("pulse_spacing", 32'(cyc - last_pulse >= G + 1), 32'd1);
                have_last  = 1;
                last_pulse = cyc;
                last_data  = din_data;
            end else begin
                check("din_data_hold", 32'(din_data), 32'(last_data));
            end
            if (done) begin
                check("done_busy_low", 32'(busy), 32'd0);
                check("done_all_pulses", 32'(exp_data.size()), 32'd0);
            end
        end
    end

    task automatic scramble_cfg();
        act_base = AW'($urandom);
        wgt_base = AW'($urandom);
        Hp = 5'($urandom);
        Wp = 5'($urandom);
        I  = 8'($urandom);
        O  = 8'($urandom);
        K  = 3'($urandom);
    endtask

    task automatic issue(input logic [AW-1:0] ab, input logic [AW-1:0] wb,
                         input int h, input int w, input int ci, input int co, input int k,
                         input logic [15:0] s, input bit stall);
        int na;
        int nw;
        logic [AW-1:0] a;
        na       = ci * h * w;
        nw       = co * ci * k * k;
        salt     = s;
        stall_en = stall;
        for (int n = 0; n < na; n++) begin
            a = ab + AW'(n);
            exp_addr.push_back(a);
            exp_data.push_back(mem_word(a));
        end
        for (int n = 0; n < nw; n++) begin
            a = wb + AW'(n);
            exp_addr.push_back(a);
            exp_data.push_back(mem_word(a));
        end
        exp_data.push_back(16'h0000);
        budget   = (na + nw + 1) * (G + 16) + 40;
        act_base = ab;
        wgt_base = wb;
        Hp = 5'(h);
        Wp = 5'(w);
        I  = 8'(ci);
        O  = 8'(co);
        K  = 3'(k);
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        scramble_cfg();
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic finish_load(input bit check_latency, input bit done_start);
        bit seen;
        seen = 0;
        for (int n = 0; n < budget; n++) begin
            if (done) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done within %0d cycles expected done", budget);
        end else if (check_latency) begin
            check("zero_dim_done_latency", 32'(cyc - start_cyc), 32'(3 + G));
        end
        if (done_start && seen) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("start_on_done_ignored", 32'(busy), 32'd0);
        end else begin
            @(negedge clk);
        end
        check("addr_queue_drained", 32'(exp_addr.size()), 32'd0);
    endtask

    initial begin
        bit found;
        rst   = 1'b1;
        start = 1'b0;
        rready = 1'b0;
        rdata  = '0;
        stall_en = 0;
        salt     = '0;
        act_base = '0;
        wgt_base = '0;
        Hp = '0; Wp = '0; I = '0; O = '0; K = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_rvalid", 32'(rvalid), 32'd0);
        check("reset_raddr", 32'(raddr), 32'd0);
        check("reset_din_valid", 32'(din_valid), 32'd0);
        check("reset_din_data", 32'(din_data), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic run: memory returns its address.
        issue(26'h100, 26'h200, 2, 2, 1, 1, 1, 16'h0000, 0);
        finish_load(0, 0);

        // Mid-size run with stalls and an ignored start while busy.
        issue(AW'($urandom), AW'($urandom), 6, 6, 5, 5, 3, 16'($urandom), 1);
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_load(0, 0);

        // Random shapes, including address wrap near the top of memory.
        for (int r = 0; r < 8; r++) begin
            logic [AW-1:0] ab;
            ab = (r % 2 == 0) ? AW'((1 << AW) - int'($urandom_range(1, 8))) : AW'($urandom);
            issue(ab, AW'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  16'($urandom), bit'($urandom_range(0, 1)));
            finish_load(0, 0);
        end

        // Zero input channels: trigger only, fixed latency.
        issue(AW'($urandom), AW'($urandom), 3, 3, 0, 4, 2, 16'($urandom), 1);
        finish_load(1, 0);

        // Zero kernel: activations then trigger.
        issue(AW'($urandom), AW'($urandom), 2, 3, 2, 3, 0, 16'($urandom), 1);
        finish_load(0, 0);

        // Start on the done cycle is ignored; start on the next cycle loads.
        issue(AW'($urandom), AW'($urandom), 1, 2, 1, 1, 1, 16'($urandom), 0);
        finish_load(0, 1);
        issue(AW'($urandom), AW'($urandom), 2, 1, 1, 2, 1, 16'($urandom), 0);
        finish_load(0, 0);

        // Reset during the third activation request, then replay.
        issue(26'h3000, 26'h4000, 2, 2, 2, 1, 1, 16'h5A5A, 1);
        found = 0;
        for (int n = 0; n < 200; n++) begin
            if (rvalid && raddr == 26'h3002) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("third_request_seen", 32'(found), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_rvalid", 32'(rvalid), 32'd0);
        check("async_rst_din_valid", 32'(din_valid), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        exp_data.delete();
        exp_addr.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_idle", 32'(busy), 32'd0);
        issue(26'h3000, 26'h4000, 2, 2, 2, 1, 1, 16'h5A5A, 1);
        finish_load(0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
